pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits (>=8).
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: PC loaded by reset.
REQ-003 Parameter EXC_VEC, default 32'h8000_0180: PC loaded on exception.
REQ-004 Parameter INC, default 4: sequential increment.
REQ-005 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port stall  in  1  hold fetch PC (hazard unit); active-high.
REQ-008 Port redir_valid  in  1  branch/jump redirect request this cycle.
REQ-009 Port redir_target  in  WIDTH  redirect destination.
REQ-010 Port exc_valid  in  1  exception request; highest priority.
REQ-011 Port pc_f  out  WIDTH  current fetch PC (registered).
REQ-012 Port pc_plus_f  out  WIDTH  pc_f + INC (combinational from pc_f).
REQ-013 Port valid_f  out  1  pc_f is a real fetch address (registered).
REQ-014 Port misalign_f  out  1  pc_f[1:0] != 0 (combinational).
REQ-015 Port pend_f  out  1  a redirect is buffered awaiting stall release.

Function
REQ-016 States: BOOT, RUN, PEND; state, pc_f, valid_f, pending target are registers.
REQ-017 Next-PC priority per edge: exc_valid > buffered/new redirect > stall hold > pc_f+INC.
REQ-018 exc_valid=1 (any state, stall ignored): pc_f<=EXC_VEC, pending discarded, state<=RUN, valid_f<=1.
REQ-019 RUN, stall=0, redir_valid=1: pc_f<=redir_target next edge (1-cycle latency).
REQ-020 RUN, stall=0, redir_valid=0: pc_f<=pc_f+INC, modulo 2^WIDTH (wrap, no flag).
REQ-021 RUN, stall=1, redir_valid=0: pc_f holds.
REQ-022 RUN, stall=1, redir_valid=1: target captured in pending register, pc_f holds, state<=PEND.
REQ-023 PEND, stall=1: pc_f holds; a new redir_valid overwrites the pending target (latest wins).
REQ-024 PEND, stall=0: pc_f<=redir_valid ? redir_target : pending target; state<=RUN.
REQ-025 pend_f=1 exactly while state==PEND.
REQ-026 BOOT: entered by reset; valid_f=0; pc_f holds RESET_VEC regardless of stall/redir.
REQ-027 BOOT exits to RUN on first edge after rst deasserts with stall=0: pc_f stays RESET_VEC, valid_f<=1; with stall=1 stays BOOT.
REQ-028 exc_valid in BOOT behaves per REQ-018.
REQ-029 misalign_f does not alter next-PC; it is reported only.

Reset
REQ-030 rst=1 at an edge: pc_f<=RESET_VEC, valid_f<=0, state<=BOOT, pending target<=0, overriding all other inputs.
REQ-031 Reset mid-PEND discards the buffered redirect.
REQ-032 Post-reset output values: pc_f=RESET_VEC, pc_plus_f=RESET_VEC+INC, valid_f=0, pend_f=0, misalign_f=RESET_VEC[1:0]!=0.

Structure
REQ-033 Shared package holds the state enum (BOOT/RUN/PEND) and default vector constants RESET_VEC_DEF, EXC_VEC_DEF, PC_INC_DEF.
REQ-034 Single module; optional sub-module pc_pend_buf (pending target register + valid bit) only.
REQ-035 No latches; one combinational next-PC mux feeding one registered block.

Verification
REQ-036 Reset then stall=0 for 3 cycles -> pc_f: 0,0,4,8; valid_f: 0,1,1,1.
REQ-037 pc_f=0x40, redir_valid=1 target=0x100, stall=0 -> next pc_f=0x100, then 0x104.
REQ-038 pc_f=0x40, stall=1 with redir 0x200 then redir 0x300 (still stalled), stall released -> pend_f=1 during stall, pc_f held 0x40, then 0x300.
REQ-039 PEND with target 0x200, exc_valid=1 while stall=1 -> pc_f=0x8000_0180, pend_f=0, next 0x8000_0184.
REQ-040 WIDTH=32, pc_f=0xFFFF_FFFC, stall=0 -> pc_f=0x0000_0000, no error; redir 0x102 -> misalign_f=1.
REQ-041 rst=1 asserted while PEND -> pc_f=RESET_VEC, pend_f=0, valid_f=0; buffered target never appears.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator.
//   pc_state_e    : controller states (BOOT after reset, RUN fetching, PEND
//                   holding a redirect that arrived while stalled)
//   RESET_VEC_DEF : default reset vector
//   EXC_VEC_DEF   : default exception vector
//   PC_INC_DEF    : default sequential increment in bytes
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0180;
    localparam int unsigned PC_INC_DEF    = 4;

endpackage

// File: rtl/pc_pend_buf.sv
// Pending redirect buffer: holds the most recent redirect target seen while
// the fetch stage is stalled, plus a bit saying the target is live.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears target and bit)
//   clear        : drop the buffered target (consumed or discarded)
//   load         : capture target_in (latest load wins; load beats clear)
//   target_in    : redirect destination to capture
//   target       : buffered destination
//   valid        : target holds a live redirect
module pc_pend_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] target_in,
    output logic [WIDTH-1:0] target,
    output logic             valid
);

    logic [WIDTH-1:0] target_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            target_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (load) begin
            target_reg <= target_in;
            valid_reg  <= 1'b1;
        end else if (clear) begin
            valid_reg  <= 1'b0;
        end
    end

    assign target = target_reg;
    assign valid  = valid_reg;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// Next-PC priority each edge: exception > redirect (buffered or new) >
// stall hold > sequential increment. A redirect arriving while stalled is
// parked in pc_pend_buf and applied on the first unstalled edge.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   stall         : hold the fetch PC
//   redir_valid   : redirect request, destination in redir_target
//   exc_valid     : exception request (overrides stall and redirects)
//   pc_f          : registered fetch PC
//   pc_plus_f     : pc_f + INC
//   valid_f       : pc_f is a real fetch address
//   misalign_f    : pc_f low two bits non-zero (report only)
//   pend_f        : a redirect is waiting for the stall to release
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0]   EXC_VEC   = WIDTH'(EXC_VEC_DEF),
    parameter int unsigned        INC       = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_valid,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus_f,
    output logic             valid_f,
    output logic             misalign_f,
    output logic             pend_f
);

    pc_state_e        state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             valid_reg, valid_next;
    logic [WIDTH-1:0] pc_inc;
    logic             buf_load, buf_clear;
    logic [WIDTH-1:0] pend_target;
    logic             pend_valid;

    pc_pend_buf #(.WIDTH(WIDTH)) u_pend_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .load      (buf_load),
        .target_in (redir_target),
        .target    (pend_target),
        .valid     (pend_valid)
    );

    // Wraps modulo 2^WIDTH by construction.
    assign pc_inc = pc_reg + WIDTH'(INC);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        if (exc_valid) begin
            pc_next    = EXC_VEC;
            state_next = RUN;
            valid_next = 1'b1;
            buf_clear  = 1'b1;
        end else begin
            unique case (state_reg)
                BOOT: begin
                    // PC parked on the reset vector; redirects are ignored.
                    pc_next = RESET_VEC;
                    if (!stall) begin
                        state_next = RUN;
                        valid_next = 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        pc_next = redir_valid ? redir_target : pc_inc;
                    end else if (redir_valid) begin
                        buf_load   = 1'b1;
                        state_next = PEND;
                    end
                end
                PEND: begin
                    if (stall) begin
                        buf_load = redir_valid;
                    end else begin
                        // A fresh redirect on the release edge is newer than
                        // the buffered one.
                        if (redir_valid)     pc_next = redir_target;
                        else if (pend_valid) pc_next = pend_target;
                        buf_clear  = 1'b1;
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = BOOT;
                    pc_next    = RESET_VEC;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_VEC;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
        end
    end

    assign pc_f       = pc_reg;
    assign pc_plus_f  = pc_inc;
    assign valid_f    = valid_reg;
    assign misalign_f = |pc_reg[1:0];
    assign pend_f     = (state_reg == PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen with default parameters.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_valid;
    logic [31:0] pc_f;
    logic [31:0] pc_plus_f;
    logic        valid_f;
    logic        misalign_f;
    logic        pend_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .exc_valid    (exc_valid),
        .pc_f         (pc_f),
        .pc_plus_f    (pc_plus_f),
        .valid_f      (valid_f),
        .misalign_f   (misalign_f),
        .pend_f       (pend_f)
    );

    // Apply one set of inputs across a rising edge, then sample 1 ns later.
    task automatic tick(input logic r, input logic s, input logic rv,
                        input logic [31:0] rt, input logic e);
        rst = r; stall = s; redir_valid = rv; redir_target = rt; exc_valid = e;
        @(posedge clk);
        #1;
        $display("txn rst=%0b stall=%0b redir=%0b tgt=%h exc=%0b -> pc_f=%h valid_f=%0b pend_f=%0b mis=%0b",
                 r, s, rv, rt, e, pc_f, valid_f, pend_f, misalign_f);
    endtask

    task automatic test_reset();
        tick(1, 0, 1, 32'h0000_0abc, 0);
        checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h expected=%h", pc_f, 32'h0); end
        checks++; if (pc_plus_f !== 32'h4) begin errors++; $display("FAIL reset_pc_plus actual=%h expected=%h", pc_plus_f, 32'h4); end
        checks++; if (valid_f !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b expected=0", valid_f); end
        checks++; if (pend_f !== 1'b0) begin errors++; $display("FAIL reset_pend actual=%b expected=0", pend_f); end
        checks++; if (misalign_f !== 1'b0) begin errors++; $display("FAIL reset_misalign actual=%b expected=0", misalign_f); end
    endtask

    task automatic test_boot();
        // Stalled: remain in BOOT, redirect ignored.
        tick(0, 1, 1, 32'h0000_0044, 0);
        checks++; if (pc_f !== 32'h0 || valid_f !== 1'b0) begin errors++; $display("FAIL boot_stall actual=%h/%b expected=%h/0", pc_f, valid_f, 32'h0); end
        // Release: PC stays on reset vector, becomes valid, then counts.
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h0 || valid_f !== 1'b1) begin errors++; $display("FAIL boot_exit actual=%h/%b expected=%h/1", pc_f, valid_f, 32'h0); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h4 || valid_f !== 1'b1) begin errors++; $display("FAIL seq_4 actual=%h/%b expected=%h/1", pc_f, valid_f, 32'h4); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h8) begin errors++; $display("FAIL seq_8 actual=%h expected=%h", pc_f, 32'h8); end
    endtask

    task automatic test_redirect();
        tick(0, 0, 1, 32'h0000_0040, 0);
        checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL redir_40 actual=%h expected=%h", pc_f, 32'h40); end
        tick(0, 0, 1, 32'h0000_0100, 0);
        checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL redir_100 actual=%h expected=%h", pc_f, 32'h100); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h104) begin errors++; $display("FAIL after_redir actual=%h expected=%h", pc_f, 32'h104); end
        // Plain stall without redirect holds.
        tick(0, 1, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h104 || pend_f !== 1'b0) begin errors++; $display("FAIL stall_hold actual=%h/%b expected=%h/0", pc_f, pend_f, 32'h104); end
    endtask

    task automatic test_pend();
        tick(0, 0, 1, 32'h0000_0040, 0);
        tick(0, 1, 1, 32'h0000_0200, 0);
        checks++; if (pc_f !== 32'h40 || pend_f !== 1'b1) begin errors++; $display("FAIL pend_first actual=%h/%b expected=%h/1", pc_f, pend_f, 32'h40); end
        tick(0, 1, 1, 32'h0000_0300, 0);
        checks++; if (pc_f !== 32'h40 || pend_f !== 1'b1) begin errors++; $display("FAIL pend_second actual=%h/%b expected=%h/1", pc_f, pend_f, 32'h40); end
        tick(0, 1, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h40 || pend_f !== 1'b1) begin errors++; $display("FAIL pend_hold actual=%h/%b expected=%h/1", pc_f, pend_f, 32'h40); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h300 || pend_f !== 1'b0) begin errors++; $display("FAIL pend_release actual=%h/%b expected=%h/0", pc_f, pend_f, 32'h300); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h304) begin errors++; $display("FAIL pend_after actual=%h expected=%h", pc_f, 32'h304); end
        // New redirect on the release edge beats the buffered one.
        tick(0, 1, 1, 32'h0000_0500, 0);
        tick(0, 0, 1, 32'h0000_0600, 0);
        checks++; if (pc_f !== 32'h600 || pend_f !== 1'b0) begin errors++; $display("FAIL pend_new_wins actual=%h/%b expected=%h/0", pc_f, pend_f, 32'h600); end
    endtask

    task automatic test_exception();
        tick(0, 1, 1, 32'h0000_0200, 0);
        checks++; if (pend_f !== 1'b1) begin errors++; $display("FAIL exc_setup_pend actual=%b expected=1", pend_f); end
        tick(0, 1, 0, 32'h0, 1);
        checks++; if (pc_f !== 32'h8000_0180 || pend_f !== 1'b0 || valid_f !== 1'b1) begin errors++; $display("FAIL exc_in_pend actual=%h/%b/%b expected=%h/0/1", pc_f, pend_f, valid_f, 32'h8000_0180); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h8000_0184) begin errors++; $display("FAIL exc_next actual=%h expected=%h", pc_f, 32'h8000_0184); end
        // Exception outranks a same-cycle redirect.
        tick(0, 0, 1, 32'h0000_0900, 1);
        checks++; if (pc_f !== 32'h8000_0180) begin errors++; $display("FAIL exc_over_redir actual=%h expected=%h", pc_f, 32'h8000_0180); end
    endtask

    task automatic test_wrap_misalign();
        tick(0, 0, 1, 32'hFFFF_FFFC, 0);
        checks++; if (pc_f !== 32'hFFFF_FFFC || pc_plus_f !== 32'h0) begin errors++; $display("FAIL wrap_setup actual=%h/%h expected=%h/%h", pc_f, pc_plus_f, 32'hFFFF_FFFC, 32'h0); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h0 || valid_f !== 1'b1) begin errors++; $display("FAIL wrap actual=%h/%b expected=%h/1", pc_f, valid_f, 32'h0); end
        tick(0, 0, 1, 32'h0000_0102, 0);
        checks++; if (pc_f !== 32'h102 || misalign_f !== 1'b1) begin errors++; $display("FAIL misalign actual=%h/%b expected=%h/1", pc_f, misalign_f, 32'h102); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h106 || pc_plus_f !== 32'h10A || misalign_f !== 1'b1) begin errors++; $display("FAIL misalign_seq actual=%h/%h/%b expected=%h/%h/1", pc_f, pc_plus_f, misalign_f, 32'h106, 32'h10A); end
    endtask

    task automatic test_reset_pend();
        tick(0, 0, 1, 32'h0000_0040, 0);
        tick(0, 1, 1, 32'h0000_0700, 0);
        checks++; if (pend_f !== 1'b1) begin errors++; $display("FAIL rp_setup actual=%b expected=1", pend_f); end
        tick(1, 1, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h0 || pend_f !== 1'b0 || valid_f !== 1'b0) begin errors++; $display("FAIL rp_reset actual=%h/%b/%b expected=%h/0/0", pc_f, pend_f, valid_f, 32'h0); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h0 || valid_f !== 1'b1) begin errors++; $display("FAIL rp_boot_exit actual=%h/%b expected=%h/1", pc_f, valid_f, 32'h0); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h4) begin errors++; $display("FAIL rp_no_stale actual=%h expected=%h", pc_f, 32'h4); end
    endtask

    task automatic test_exc_boot();
        tick(1, 0, 0, 32'h0, 0);
        tick(0, 1, 0, 32'h0, 1);
        checks++; if (pc_f !== 32'h8000_0180 || valid_f !== 1'b1) begin errors++; $display("FAIL exc_boot actual=%h/%b expected=%h/1", pc_f, valid_f, 32'h8000_0180); end
        tick(0, 0, 0, 32'h0, 0);
        checks++; if (pc_f !== 32'h8000_0184) begin errors++; $display("FAIL exc_boot_next actual=%h expected=%h", pc_f, 32'h8000_0184); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0; exc_valid = 1'b0;
        test_reset();
        test_boot();
        test_redirect();
        test_pend();
        test_exception();
        test_wrap_misalign();
        test_reset_pend();
        test_exc_boot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
